// File: rtl/datamem_param.sv
// Parametrised data memory: two combinational read ports and one run-gated write port,
// initialised from an external init ROM. The optional DATAMEM_WR_BYPASS_EN macro adds write-through forwarding.
module datamem_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] write_select,
  input  logic [DATA_W-1:0] inp,
  input  logic [ADDR_W-1:0] read_select_a,
  input  logic [ADDR_W-1:0] read_select_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              reload_req,
  output logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic              ready,
  output logic              wr_dropped
);

  // state  | meaning
  // S_LOAD | copying the init image, one word per clock; writes dropped
  // S_IDLE | initialised; run & wr_en writes the array
  typedef enum logic {S_LOAD = 1'b0, S_IDLE = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_init_addr, w_init_addr_nxt;
  logic                r_wr_dropped;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];
  logic                w_wr_req;
  logic                w_last;

  assign w_wr_req = run & wr_en;
  assign w_last   = &r_init_addr;

  always_comb begin
    w_state_nxt     = r_state;
    w_init_addr_nxt = r_init_addr;
    if (r_state == S_LOAD) begin
      if (w_last) begin
        w_state_nxt     = S_IDLE;
        w_init_addr_nxt = '0;
      end else begin
        w_init_addr_nxt = r_init_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else if (reload_req) begin
      w_state_nxt     = S_LOAD;
      w_init_addr_nxt = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_init_addr  <= '0;
      r_wr_dropped <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_init_addr  <= w_init_addr_nxt;
      r_wr_dropped <= (r_state == S_LOAD) & w_wr_req;
    end
  end

  // Array has no reset; any word touched while reset is held is rewritten by the following LOAD.
  always_ff @(posedge clock) begin
    if (r_state == S_LOAD) begin
      r_mem[r_init_addr] <= init_data;
    end else if (w_wr_req) begin
      r_mem[write_select] <= inp;
    end
  end

`ifdef DATAMEM_WR_BYPASS_EN
  logic w_fwd;
  assign w_fwd      = (r_state == S_IDLE) & w_wr_req;
  assign data_out_a = (w_fwd && (read_select_a == write_select)) ? inp : r_mem[read_select_a];
  assign data_out_b = (w_fwd && (read_select_b == write_select)) ? inp : r_mem[read_select_b];
`else
  assign data_out_a = r_mem[read_select_a];
  assign data_out_b = r_mem[read_select_b];
`endif

  assign init_addr  = r_init_addr;
  assign ready      = (r_state == S_IDLE);
  assign wr_dropped = r_wr_dropped;

endmodule

// File: tb/tb_datamem_param.sv
// Bench for datamem_param: a word-array reference model with a per-cycle compare,
// plus literal scenario checks and a randomized phase.
module tb_datamem_param;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              run, wr_en, reload_req;
  logic [ADDR_W-1:0] write_select, read_select_a, read_select_b, init_addr;
  logic [DATA_W-1:0] inp, data_out_a, data_out_b, init_data;
  logic              ready, wr_dropped;
  logic [DATA_W-1:0] rom_base;

  int n_checks = 0;
  int n_errors = 0;

  datamem_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .run(run), .wr_en(wr_en),
    .write_select(write_select), .inp(inp),
    .read_select_a(read_select_a), .read_select_b(read_select_b),
    .data_out_a(data_out_a), .data_out_b(data_out_b),
    .reload_req(reload_req), .init_addr(init_addr), .init_data(init_data),
    .ready(ready), .wr_dropped(wr_dropped)
  );

  always #5 clock = ~clock;

  assign init_data = rom_base + {4'b0000, init_addr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: loading flag, count of words already copied, the word array.
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_valid [DEPTH];
  bit                m_loading = 1'b1;
  int                m_idx = 0;
  bit                m_dropped = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_loading = 1'b1;
      m_idx     = 0;
      m_dropped = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    end else if (m_loading) begin
      m_mem[m_idx]   = rom_base + 8'(m_idx);
      m_valid[m_idx] = 1'b1;
      m_dropped      = run && wr_en;
      m_idx          = m_idx + 1;
      if (m_idx == DEPTH) begin
        m_loading = 1'b0;
        m_idx     = 0;
      end
    end else begin
      m_dropped = 1'b0;
      if (run && wr_en) begin
        m_mem[write_select]   = inp;
        m_valid[write_select] = 1'b1;
      end
      if (reload_req) m_loading = 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] sel);
    logic [DATA_W-1:0] v;
    v = m_mem[sel];
`ifdef DATAMEM_WR_BYPASS_EN
    if (!m_loading && !reset && run && wr_en && sel == write_select) v = inp;
`endif
    return v;
  endfunction

  always @(negedge clock) begin
    if ($time > 2) begin
      check("ready", 32'(ready), 32'(!m_loading));
      check("wr_dropped", 32'(wr_dropped), 32'(m_dropped));
      check("init_addr", 32'(init_addr), 32'(m_idx));
      if (!reset && m_valid[read_select_a]) check("data_out_a", 32'(data_out_a), 32'(model_read(read_select_a)));
      if (!reset && m_valid[read_select_b]) check("data_out_b", 32'(data_out_b), 32'(model_read(read_select_b)));
    end
  end

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; wr_en = 1'b0; reload_req = 1'b0;
    write_select = '0; inp = '0; read_select_a = '0; read_select_b = '0;
    rom_base = 8'hA0;
    #1 reset = 1'b1;
    edges(3);
    reset = 1'b0;

    // Initial load: ready low for 15 edges, high after the 16th
    for (int i = 1; i <= DEPTH; i++) begin
      edges(1);
      if (i == DEPTH - 1) check("ready_before_16", 32'(ready), 32'd0);
      if (i == DEPTH)     check("ready_at_16", 32'(ready), 32'd1);
    end
    read_select_a = 4'd5; read_select_b = 4'd15;
    #1;
    check("init_a5", 32'(data_out_a), 32'h A5);
    check("init_b15", 32'(data_out_b), 32'h AF);

    // Write/read
    run = 1'b1; wr_en = 1'b1; write_select = 4'd3; inp = 8'h5C;
    read_select_a = 4'd3; read_select_b = 4'd3;
    edges(1);
    wr_en = 1'b0;
    #1;
    check("wr_a3", 32'(data_out_a), 32'h5C);
    check("wr_b3", 32'(data_out_b), 32'h5C);
    run = 1'b0; wr_en = 1'b1; inp = 8'hFF;
    edges(1);
    check("norun_a3", 32'(data_out_a), 32'h5C);
    check("norun_dropped", 32'(wr_dropped), 32'd0);
    wr_en = 1'b0;

    // Reload with a mid-load reload pulse
    run = 1'b1; wr_en = 1'b1; write_select = 4'd0; inp = 8'h11; read_select_a = 4'd0;
    edges(1);
    wr_en = 1'b0;
    #1 check("wr_a0", 32'(data_out_a), 32'h11);
    reload_req = 1'b1;
    edges(1);
    reload_req = 1'b0;
    check("reload_ready_low", 32'(ready), 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      reload_req = (i == 5);
      edges(1);
      if (i == DEPTH - 1) check("reload_ready_15", 32'(ready), 32'd0);
      if (i == DEPTH)     check("reload_ready_16", 32'(ready), 32'd1);
    end
    reload_req = 1'b0;
    check("reload_a0", 32'(data_out_a), 32'hA0);

    // Dropped write during LOAD
    reload_req = 1'b1;
    edges(1);
    reload_req = 1'b0;
    edges(2);
    run = 1'b1; wr_en = 1'b1; write_select = 4'd7; inp = 8'h33;
    edges(1);
    wr_en = 1'b0;
    check("drop_pulse", 32'(wr_dropped), 32'd1);
    edges(1);
    check("drop_pulse_end", 32'(wr_dropped), 32'd0);
    edges(DEPTH - 4);
    check("drop_ready", 32'(ready), 32'd1);
    read_select_a = 4'd7;
    #1 check("drop_a7", 32'(data_out_a), 32'hA7);

    // Reset mid-LOAD, partial load uses a different image
    rom_base = 8'h50;
    reload_req = 1'b1;
    edges(1);
    reload_req = 1'b0;
    edges(9);
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_init_addr", 32'(init_addr), 32'd0);
    rom_base = 8'hA0;
    edges(2);
    reset = 1'b0;
    edges(DEPTH - 1);
    check("rst_ready_15", 32'(ready), 32'd0);
    edges(1);
    check("rst_ready_16", 32'(ready), 32'd1);
    read_select_a = 4'd3; read_select_b = 4'd9;
    #1;
    check("rst_a3", 32'(data_out_a), 32'hA3);
    check("rst_b9", 32'(data_out_b), 32'hA9);

    // Bypass behaviour
    read_select_a = 4'd4; write_select = 4'd4; inp = 8'h9E; run = 1'b1; wr_en = 1'b1;
    #1;
`ifdef DATAMEM_WR_BYPASS_EN
    check("byp_before", 32'(data_out_a), 32'h9E);
`else
    check("byp_before", 32'(data_out_a), 32'hA4);
`endif
    edges(1);
    wr_en = 1'b0;
    #1 check("byp_after", 32'(data_out_a), 32'h9E);

    // Randomized phase
    rom_base = 8'($urandom);
    for (int c = 0; c < 800; c++) begin
      edges(1);
      reset         = ($urandom_range(0, 199) == 0);
      run           = ($urandom_range(0, 3) != 0);
      wr_en         = ($urandom_range(0, 1) == 1);
      reload_req    = ($urandom_range(0, 29) == 0);
      write_select  = 4'($urandom);
      read_select_a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : write_select;
      read_select_b = 4'($urandom);
      inp           = 8'($urandom);
    end
    reset = 1'b0; run = 1'b0; wr_en = 1'b0; reload_req = 1'b0;
    edges(DEPTH + 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/datamem_param.md
Name: datamem_param

Overview:
- Parametrised successor to the CPU's 16x8 data memory.
- Configurable width and depth, two independent combinational read ports, and one gated write port.
- Contents are initialised by a sequencer that copies an external init image (user-data ROM) one word per clock.
- Used after reset and on software/debug reload request; sits between datapath and user-data ROM.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  CPU run enable; gates normal writes
wr_en  input  1  write enable (control bit c17)
write_select  input  ADDR_W  write address
inp  input  DATA_W  write data
read_select_a  input  ADDR_W  read address, port A
read_select_b  input  ADDR_W  read address, port B
data_out_a  output  DATA_W  combinational read data, port A
data_out_b  output  DATA_W  combinational read data, port B
reload_req  input  1  request re-initialisation from init image
init_addr  output  ADDR_W  address presented to init ROM
init_data  input  DATA_W  init ROM word at init_addr (combinational)
ready  output  1  high when memory initialised and accepting writes
wr_dropped  output  1  one-cycle pulse: write attempted during LOAD

Behaviour:
- One clock domain; reset is asynchronous and active-high; ports named clock and reset.
- Reset asserted: state=LOAD, init_addr=0, ready=0, wr_dropped=0.
  - Array contents not cleared by reset; they are rewritten by LOAD.
- FSM states: LOAD, IDLE.
- LOAD:
  - Each rising edge writes mem[init_addr] <= init_data, then init_addr increments.
  - On the edge that writes address DEPTH-1: state -> IDLE, ready -> 1, init_addr -> 0.
  - Full load = exactly DEPTH edges after reset release; no wrap beyond DEPTH-1.
  - Load proceeds regardless of run.
- IDLE:
  - run & wr_en: mem[write_select] <= inp on rising edge.
  - reload_req sampled high: next edge state -> LOAD, ready -> 0, init_addr=0.
  - If a write is also active on that edge, the write is performed first and is later overwritten by LOAD.
- Writes during LOAD:
  - run & wr_en high in LOAD: write discarded; wr_dropped high for the following cycle only.
  - Consecutive attempts give consecutive high cycles.
- reload_req during LOAD is ignored; the sequence is not restarted.
- run low: writes ignored silently; wr_dropped stays 0.
- Reads:
  - data_out_a = mem[read_select_a] and data_out_b = mem[read_select_b], purely combinational, zero latency.
  - Both ports may address the same word.
  - A read of the address being written returns the old value until the edge, unless the optional feature is enabled.
- Reset asserted mid-LOAD or mid-IDLE: immediate return to the reset state; a fresh full LOAD follows release.
- All address arithmetic is modulo DEPTH; no out-of-range addresses exist.

Optional Feature:
- Macro: DATAMEM_WR_BYPASS_EN.
- Defined:
  - In IDLE with run & wr_en, a read port whose select equals write_select outputs inp combinationally (write-through forwarding).
  - Both ports forward independently.
  - No forwarding in LOAD.
- Undefined: reads always return stored array contents; no forwarding path is instantiated.

Test Plan:
- Init: init ROM returns 8'hA0+addr; release reset -> ready=0 for 16 edges, ready=1 after 16th; data_out_a at addr 5 = 8'hA5, at addr 15 = 8'hAF.
- Write/read: in IDLE, run=1, wr_en=1, write_select=3, inp=8'h5C, one edge -> data_out_a(3)=8'h5C and data_out_b(3)=8'h5C; run=0 write of 8'hFF to 3 -> still 8'h5C, wr_dropped=0.
- Reload: write 8'h11 to addr 0, then pulse reload_req -> ready=0 next cycle; 16 edges later ready=1, addr 0 reads 8'hA0; reload_req pulsed mid-LOAD -> ready still rises on schedule.
- Dropped write: run=1, wr_en=1, addr 7, inp=8'h33 at LOAD cycle 2 -> wr_dropped=1 for exactly one cycle; after load, addr 7 = 8'hA7.
- Reset mid-LOAD: assert reset at LOAD cycle 9 -> ready=0, init_addr=0 immediately; after release a full 16-edge load completes with correct image.
- Bypass (DATAMEM_WR_BYPASS_EN defined): addr 4 holds 8'hA4; write 8'h9E to 4 with read_select_a=4 -> data_out_a=8'h9E before the edge; macro undefined -> 8'hA4 before the edge, 8'h9E after.
